display_scan_ctrl: RTL

//  Scan controller for the 4-digit hex 7-segment display; sits upstream of the 4:1 nibble mux.

---
 rtl/display_pkg.sv | 10 +
 rtl/refresh_tick_gen.sv | 23 ++
 rtl/display_scan_ctrl.sv | 77 +++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the 4-digit hex 7-segment scan controller.
package display_pkg;
   localparam int unsigned NUM_DIGITS = 4;
   localparam int unsigned NIBBLE_W   = 4;
   localparam int unsigned VALUE_W    = NUM_DIGITS * NIBBLE_W;
   localparam logic [3:0]  ANODES_OFF = 4'b1111;

   typedef logic [1:0] digit_sel_t;
   typedef logic [3:0] nibble_t;
endpackage

// File: rtl/refresh_tick_gen.sv
// Free-running prescaler: counts 0..DIV-1 and flags the last count of each slot.
module refresh_tick_gen #(
   parameter int unsigned DIV   = 100000,
   parameter int unsigned CNT_W = $clog2(DIV)
) (
   input  logic             clk,
   input  logic             reset,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_tick_c
);
   logic [CNT_W-1:0] r_cnt;
   logic             w_wrap;

   assign w_wrap   = (r_cnt == CNT_W'(DIV - 1));
   assign o_tick_c = w_wrap;
   assign o_cnt    = r_cnt;

   always_ff @(posedge clk) begin
      if (reset)       r_cnt <= '0;
      else if (w_wrap) r_cnt <= '0;
      else             r_cnt <= r_cnt + CNT_W'(1);
   end
endmodule

// File: rtl/display_scan_ctrl.sv
// Digit scan controller: shadow value, digit select, blanking and leading-zero suppression
// feeding registered active-low anode enables.
module display_scan_ctrl
   import display_pkg::*;
#(
   parameter int unsigned REFRESH_DIV  = 100000,
   parameter int unsigned BLANK_CYCLES = 16,
   parameter int unsigned LZ_SUPPRESS  = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic               load,
   input  logic [VALUE_W-1:0] value,
   output nibble_t            bus1,
   output nibble_t            bus2,
   output nibble_t            bus3,
   output nibble_t            bus4,
   output digit_sel_t         contador,
   output logic [3:0]         anodes
);
   localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

   logic [VALUE_W-1:0]    r_shadow;
   digit_sel_t            r_contador;
   logic [3:0]            r_anodes;

   logic [CNT_W-1:0]      w_cnt;
   logic                  w_tick;
   logic                  w_blank;
   logic [NUM_DIGITS-1:0] w_supp;
   logic [3:0]            w_digit_oh;
   logic [3:0]            w_anode_req;

   refresh_tick_gen #(
      .DIV   (REFRESH_DIV),
      .CNT_W (CNT_W)
   ) u_tick (
      .clk      (clk),
      .reset    (reset),
      .o_cnt    (w_cnt),
      .o_tick_c (w_tick)
   );

   // A digit is a leading zero when it and every more significant nibble are zero; digit 0 always shows.
   always_comb begin
      w_supp = '0;
      if (LZ_SUPPRESS != 0) begin
         for (int k = 1; k < int'(NUM_DIGITS); k++) begin
            w_supp[k] = ((r_shadow >> (NIBBLE_W * k)) == '0);
         end
      end
   end

   assign w_blank     = (w_cnt < CNT_W'(BLANK_CYCLES));
   assign w_digit_oh  = 4'b0001 << r_contador;
   assign w_anode_req = (!en || w_blank || w_supp[r_contador]) ? ANODES_OFF : ~w_digit_oh;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_shadow   <= '0;
         r_contador <= '0;
         r_anodes   <= ANODES_OFF;
      end else begin
         r_anodes <= w_anode_req;
         if (load)   r_shadow   <= value;
         if (w_tick) r_contador <= r_contador + digit_sel_t'(1);
      end
   end

   assign bus1     = r_shadow[3:0];
   assign bus2     = r_shadow[7:4];
   assign bus3     = r_shadow[11:8];
   assign bus4     = r_shadow[15:12];
   assign contador = r_contador;
   assign anodes   = r_anodes;
endmodule
